onehot_encoder: RTL and testbench

- Inverse of the classifier index decode. Accepts a class index through a ready/start handshake and serialises it as a NUM_CLASSES-long score stream on the same en/Data interface the argmax index decoder consumes.
- Emits HOT_VAL at the selected position and COLD_VAL everywhere else, then drops en for one cycle so the downstream decoder clears.
- Used for label injection, loopback self-test and golden-stream generation in the CNN output path.

---
 rtl/onehot_encoder_pkg.sv | 26 ++
 rtl/onehot_encoder_lfsr.sv | 33 +++
 rtl/onehot_encoder.sv | 145 ++++++++++++++
 tb/tb_onehot_encoder.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/onehot_encoder_pkg.sv
// rtl/onehot_encoder_pkg.sv - shared constants, FSM encoding and LFSR constants for onehot_encoder
// Provides `INTERNAL_BITS (default datapath width), state_t, default score constants,
// and the LFSR seed/tap mask used when ONEHOT_ENCODER_NOISE_EN is defined.
`ifndef INTERNAL_BITS
`define INTERNAL_BITS 32
`endif

package onehot_encoder_pkg;

    localparam int INTERNAL_BITS = `INTERNAL_BITS;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_GAP    = 2'd2
    } state_t;

    localparam int DEF_NUM_CLASSES = 10;
    localparam int DEF_HOT_VAL     = 1000;
    localparam int DEF_COLD_VAL    = 0;

    // Fibonacci taps 16,15,13,4 expressed as a mask over bits [15:0].
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS = 16'hD008;

endpackage

// File: rtl/onehot_encoder_lfsr.sv
// rtl/onehot_encoder_lfsr.sv - 16-bit maximal Fibonacci LFSR with advance enable
// Ports: clk, rst (sync active-low, loads LFSR_SEED), advance_i (shift one step),
//        noise_o (low byte of the current LFSR state).
module onehot_encoder_lfsr
    import onehot_encoder_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       advance_i,
    output logic [7:0] noise_o
);

    logic [15:0] lfsr_q;
    logic [15:0] lfsr_d;

    always_comb begin
        lfsr_d = lfsr_q;
        if (advance_i) begin
            lfsr_d = {lfsr_q[14:0], ^(lfsr_q & LFSR_TAPS)};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            lfsr_q <= LFSR_SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign noise_o = lfsr_q[7:0];

endmodule

// File: rtl/onehot_encoder.sv
// rtl/onehot_encoder.sv - serialises a class index into a one-hot score stream on en/Data_out
// Ports: clk, rst (sync active-low), start/ready (index handshake), Index_in (unsigned index),
//        en/Data_out (score stream), done (pulse in the gap cycle), err (pulse on bad index).
// Optional macro: ONEHOT_ENCODER_NOISE_EN replaces cold scores with 8-bit LFSR noise.
module onehot_encoder
    import onehot_encoder_pkg::*;
#(
    parameter int DATA_W      = `INTERNAL_BITS,
    parameter int NUM_CLASSES = DEF_NUM_CLASSES,
    parameter int HOT_VAL     = DEF_HOT_VAL,
    parameter int COLD_VAL    = DEF_COLD_VAL
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] Index_in,
    output logic              ready,
    output logic              en,
    output logic [DATA_W-1:0] Data_out,
    output logic              done,
    output logic              err
);

    localparam int                CW      = $clog2(NUM_CLASSES) + 1;
    localparam logic [CW-1:0]     LAST    = CW'(NUM_CLASSES - 1);
    // One extra bit so the range check stays correct when NUM_CLASSES == 2**DATA_W.
    localparam logic [DATA_W:0]   NUM_EXT = (DATA_W + 1)'(NUM_CLASSES);
    localparam logic [DATA_W-1:0] HOT_W   = DATA_W'(HOT_VAL);
    localparam logic [DATA_W-1:0] COLD_W  = DATA_W'(COLD_VAL);

    if (NUM_CLASSES < 2 || NUM_CLASSES > 65536) begin : g_bad_num_classes
        $error("onehot_encoder: NUM_CLASSES out of range");
    end
    if (HOT_VAL <= 0 || HOT_VAL <= COLD_VAL) begin : g_bad_hot_val
        $error("onehot_encoder: HOT_VAL must be positive and above COLD_VAL");
    end

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d, cnt_nxt;
    logic [DATA_W-1:0] idx_q, idx_d;
    logic              ready_q, ready_d;
    logic              en_q, en_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic [DATA_W-1:0] cold_w;

`ifdef ONEHOT_ENCODER_NOISE_EN
    if (HOT_VAL <= 255) begin : g_bad_noise_hot
        $error("onehot_encoder: HOT_VAL must exceed the 8-bit noise range");
    end

    logic [7:0] noise_w;

    // The LFSR steps once for every element loaded, so each cold slot sees a fresh byte.
    onehot_encoder_lfsr u_lfsr (
        .clk       (clk),
        .rst       (rst),
        .advance_i (en_d),
        .noise_o   (noise_w)
    );

    assign cold_w = {{(DATA_W - 8){1'b0}}, noise_w};
`else
    assign cold_w = COLD_W;
`endif

    // Outputs are registered, so each branch computes what becomes visible next cycle.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        ready_d = 1'b0;
        en_d    = 1'b0;
        data_d  = '0;
        done_d  = 1'b0;
        err_d   = 1'b0;
        cnt_nxt = cnt_q + CW'(1);

        case (state_q)
            ST_IDLE: begin
                ready_d = 1'b1;
                if (start) begin
                    if ({1'b0, Index_in} < NUM_EXT) begin
                        state_d = ST_STREAM;
                        cnt_d   = '0;
                        idx_d   = Index_in;
                        ready_d = 1'b0;
                        en_d    = 1'b1;
                        data_d  = (Index_in == '0) ? HOT_W : cold_w;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ST_STREAM: begin
                if (cnt_q == LAST) begin
                    state_d = ST_GAP;
                    done_d  = 1'b1;
                end else begin
                    cnt_d  = cnt_nxt;
                    en_d   = 1'b1;
                    data_d = (DATA_W'(cnt_nxt) == idx_q) ? HOT_W : cold_w;
                end
            end
            ST_GAP: begin
                state_d = ST_IDLE;
                ready_d = 1'b1;
            end
            default: begin
                state_d = ST_IDLE;
                ready_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            ready_q <= 1'b1;
            en_q    <= 1'b0;
            data_q  <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            ready_q <= ready_d;
            en_q    <= en_d;
            data_q  <= data_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign ready    = ready_q;
    assign en       = en_q;
    assign Data_out = data_q;
    assign done     = done_q;
    assign err      = err_q;

endmodule

// File: tb/tb_onehot_encoder.sv
// tb/tb_onehot_encoder.sv - self-checking bench for onehot_encoder
module tb_onehot_encoder;

    localparam int N   = 10;
    localparam int HOT = 1000;

    logic        clk;
    logic        rst;
    logic        start;
    logic [31:0] Index_in;
    logic        ready;
    logic        en;
    logic [31:0] Data_out;
    logic        done;
    logic        err;

    int checks   = 0;
    int failures = 0;

    onehot_encoder dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .Index_in (Index_in),
        .ready    (ready),
        .en       (en),
        .Data_out (Data_out),
        .done     (done),
        .err      (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference argmax decoder: first strict maximum wins, result published on en low.
    logic               dec_active;
    logic signed [31:0] dec_best;
    int                 dec_cnt;
    int                 dec_bidx;
    int                 dec_out;

    always @(posedge clk) begin
        if (!rst) begin
            dec_active <= 1'b0;
            dec_cnt    <= 0;
            dec_out    <= -1;
        end else if (en) begin
            if (!dec_active || $signed(Data_out) > dec_best) begin
                dec_best <= $signed(Data_out);
                dec_bidx <= dec_active ? dec_cnt : 0;
            end
            dec_cnt    <= dec_active ? dec_cnt + 1 : 1;
            dec_active <= 1'b1;
        end else if (dec_active) begin
            dec_out    <= dec_bidx;
            dec_active <= 1'b0;
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d (0x%08h) expected %0d (0x%08h) at %0t",
                     name, got, got, exp, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Checks one visible stream element at position pos of a stream whose hot index is hot_pos.
    task automatic check_elem(input int pos, input int hot_pos);
        chk("elem_en", {31'b0, en}, 32'd1);
        chk("elem_ready", {31'b0, ready}, 32'd0);
        if (pos == hot_pos) begin
            chk("elem_hot", Data_out, HOT);
        end else begin
`ifdef ONEHOT_ENCODER_NOISE_EN
            chk("elem_cold_le255", {31'b0, (Data_out <= 32'd255)}, 32'd1);
`else
            chk("elem_cold", Data_out, 32'd0);
`endif
        end
    endtask

    // One start pulse; follows the full stream or the error pulse and the decoder result.
    task automatic run_one(input logic [31:0] idx, input bit exp_err);
        start    = 1'b1;
        Index_in = idx;
        step();
        start = 1'b0;
        if (exp_err) begin
            chk("err_pulse", {31'b0, err}, 32'd1);
            chk("err_en", {31'b0, en}, 32'd0);
            chk("err_ready", {31'b0, ready}, 32'd1);
            step();
            chk("err_clear", {31'b0, err}, 32'd0);
            chk("err_en2", {31'b0, en}, 32'd0);
            chk("err_ready2", {31'b0, ready}, 32'd1);
        end else begin
            for (int k = 0; k < N; k++) begin
                check_elem(k, int'(idx));
                step();
            end
            chk("gap_en", {31'b0, en}, 32'd0);
            chk("gap_done", {31'b0, done}, 32'd1);
            chk("gap_data", Data_out, 32'd0);
            chk("gap_ready", {31'b0, ready}, 32'd0);
            step();
            chk("post_ready", {31'b0, ready}, 32'd1);
            chk("post_done", {31'b0, done}, 32'd0);
            chk("post_en", {31'b0, en}, 32'd0);
            chk("decoder_idx", dec_out, idx);
        end
    endtask

    typedef struct {
        logic [31:0] idx;
        bit          exp_err;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int          idxs[3];
        int          c;
        int          p;
        int          s;
        logic [31:0] ri;

        vecs[0] = '{32'd3,         1'b0};
        vecs[1] = '{32'd0,         1'b0};
        vecs[2] = '{32'd9,         1'b0};
        vecs[3] = '{32'd10,        1'b1};
        vecs[4] = '{32'hFFFF_FFFF, 1'b1};
        vecs[5] = '{32'd4,         1'b0};

        rst      = 1'b0;
        start    = 1'b0;
        Index_in = '0;
        repeat (3) step();
        chk("rst_ready", {31'b0, ready}, 32'd1);
        chk("rst_en", {31'b0, en}, 32'd0);
        chk("rst_data", Data_out, 32'd0);
        chk("rst_done", {31'b0, done}, 32'd0);
        chk("rst_err", {31'b0, err}, 32'd0);
        rst = 1'b1;
        step();
        chk("idle_ready", {31'b0, ready}, 32'd1);

        for (int v = 0; v < 6; v++) begin
            run_one(vecs[v].idx, vecs[v].exp_err);
        end

        // Back-to-back with start held: cycle 1 is the first accept cycle; period is N+2.
        idxs[0]  = 5;
        idxs[1]  = 2;
        idxs[2]  = 7;
        start    = 1'b1;
        Index_in = 32'd5;
        for (int e = 1; e <= 36; e++) begin
            step();
            if (e == 1)  Index_in = 32'd2;
            if (e == 13) Index_in = 32'd7;
            if (e == 25) start = 1'b0;
            c = e + 1;
            p = (c - 1) % (N + 2);
            s = (c - 1) / (N + 2);
            if (s < 3) begin
                chk("b2b_en", {31'b0, en}, {31'b0, (p >= 1 && p <= N)});
                chk("b2b_done", {31'b0, done}, {31'b0, (p == N + 1)});
                chk("b2b_ready", {31'b0, ready}, {31'b0, (p == 0)});
                if (p >= 1 && p <= N) check_elem(p - 1, idxs[s]);
                if (p == 0 && s > 0) chk("b2b_decoder", dec_out, idxs[s-1]);
            end else begin
                chk("b2b_final_ready", {31'b0, ready}, 32'd1);
                chk("b2b_final_en", {31'b0, en}, 32'd0);
                chk("b2b_final_decoder", dec_out, idxs[2]);
            end
        end

        // Reset on the 4th element of an index-6 stream.
        start    = 1'b1;
        Index_in = 32'd6;
        step();
        start = 1'b0;
        repeat (3) step();
        check_elem(3, 6);
        rst = 1'b0;
        step();
        chk("midrst_en", {31'b0, en}, 32'd0);
        chk("midrst_data", Data_out, 32'd0);
        chk("midrst_ready", {31'b0, ready}, 32'd1);
        chk("midrst_done", {31'b0, done}, 32'd0);
        rst = 1'b1;
        step();
        run_one(32'd1, 1'b0);

`ifdef ONEHOT_ENCODER_NOISE_EN
        for (int r = 0; r < 1000; r++) begin
            ri = 32'($urandom_range(0, N - 1));
            run_one(ri, 1'b0);
        end
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
